cell_in_pingpong_buffer: RTL and testbench

Downstream consumer of the systolic-array output stage. It captures the per-feature element writes that the output stage produces (write enable, address, data) into one of two ping-pong banks. Each completed frame of M elements is streamed in address order, over a valid/ready handshake, to the LSTM cell datapath. The output stage can therefore fill frame k+1 while the cell consumes frame k.

---
 rtl/lstm_acc_pkg.sv | 22 ++
 rtl/cell_in_bank.sv | 67 ++++++
 rtl/cell_in_pingpong_buffer.sv | 133 +++++++++++++
 tb/tb_cell_in_pingpong_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_acc_pkg.sv
// Shared sizing for the LSTM accelerator: output stage, cell input buffer and cell.
package lstm_acc_pkg;

    localparam int FEATURE_BITS = 4;
    localparam int ELEMENT_BITS = 8;
    localparam int M            = 9;

    // Fill counter must be able to hold the value M itself.
    localparam int CNT_BITS = $clog2(M + 1);

    localparam logic [FEATURE_BITS-1:0] LAST_INDEX = FEATURE_BITS'(M - 1);

    typedef logic [ELEMENT_BITS-1:0] element_t;
    typedef logic [FEATURE_BITS-1:0] feature_idx_t;

    // True when an element index lies inside a frame. Extended by one bit so
    // that M == 2**FEATURE_BITS compares correctly.
    function automatic logic addr_in_range(input feature_idx_t addr);
        return ({1'b0, addr} < (FEATURE_BITS + 1)'(M));
    endfunction

endpackage

// File: rtl/cell_in_bank.sv
// One ping-pong bank: element storage, per-element valid bitmap, fill counter
// and full flag. The bank goes full on the write that fills its last distinct
// slot and empties on a release pulse from the reader.
module cell_in_bank
    import lstm_acc_pkg::*;
(
    input  logic         sys_clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         wr_en,
    input  feature_idx_t wr_addr,
    input  element_t     wr_data,
    input  feature_idx_t rd_addr,
    output element_t     rd_data,
    input  logic         release_bank,
    output logic         full
);

    element_t            mem_q [0:M-1];
    logic [M-1:0]        valid_q, valid_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                full_q, full_d;

    // Track which slots have been written; count only first writes to a slot.
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        full_d  = full_q;
        if (clear || release_bank) begin
            valid_d = '0;
            count_d = '0;
            full_d  = 1'b0;
        end else if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
            if (!valid_q[wr_addr]) begin
                count_d = count_q + CNT_BITS'(1);
                if (count_q == CNT_BITS'(M - 1)) begin
                    full_d = 1'b1;
                end
            end
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Element storage; contents after reset are irrelevant because the bitmap gates use.
    always_ff @(posedge sys_clk) begin
        if (wr_en && !clear) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
    assign full    = full_q;

endmodule

// File: rtl/cell_in_pingpong_buffer.sv
// Collects element writes from the systolic output stage into two ping-pong
// banks and streams each completed frame, in address order, to the LSTM cell
// over a valid/ready handshake.
module cell_in_pingpong_buffer
    import lstm_acc_pkg::*;
(
    input  logic         sys_clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         we_load_cell,
    input  feature_idx_t address_write_load_cell,
    input  element_t     cell_in_buffer_data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output element_t     out_data,
    output feature_idx_t out_index,
    output logic         out_last,
    output logic         overflow,
    output logic         addr_err
);

    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    feature_idx_t rd_ptr_q, rd_ptr_d;
    logic         overflow_q, overflow_d;
    logic         addr_err_q, addr_err_d;

    logic [1:0]   bank_full;
    logic [1:0]   bank_we;
    logic [1:0]   bank_release;
    element_t     bank_rd_data [2];

    logic         addr_ok;
    logic         swap_now;
    logic         wr_sel;
    logic         wr_fire;
    logic         at_last;
    logic         handshake;

    // Pick the fill bank (following a pending swap immediately so back-to-back
    // frames lose no cycle), qualify the write, and qualify the handshake.
    always_comb begin
        addr_ok   = addr_in_range(address_write_load_cell);
        swap_now  = bank_full[wr_bank_q] && !bank_full[~wr_bank_q];
        wr_sel    = swap_now ? ~wr_bank_q : wr_bank_q;
        wr_fire   = we_load_cell && addr_ok && !bank_full[wr_sel] && !clear;
        at_last   = (rd_ptr_q == LAST_INDEX);
        handshake = bank_full[rd_bank_q] && out_ready && !clear;

        bank_we = 2'b00;
        if (wr_fire) begin
            bank_we[wr_sel] = 1'b1;
        end
        bank_release = 2'b00;
        if (handshake && at_last) begin
            bank_release[rd_bank_q] = 1'b1;
        end
    end

    // Next state for bank pointers, read pointer and sticky error flags.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        addr_err_d = addr_err_q;
        if (clear) begin
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            addr_err_d = 1'b0;
        end else begin
            wr_bank_d = wr_sel;
            if (we_load_cell && !addr_ok) begin
                addr_err_d = 1'b1;
            end else if (we_load_cell && bank_full[wr_sel]) begin
                overflow_d = 1'b1;
            end
            if (handshake) begin
                if (at_last) begin
                    rd_ptr_d  = '0;
                    rd_bank_d = ~rd_bank_q;
                end else begin
                    rd_ptr_d = rd_ptr_q + FEATURE_BITS'(1);
                end
            end
        end
    end

    // Control registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cell_in_bank u_bank (
            .sys_clk      (sys_clk),
            .reset_n      (reset_n),
            .clear        (clear),
            .wr_en        (bank_we[b]),
            .wr_addr      (address_write_load_cell),
            .wr_data      (cell_in_buffer_data_in),
            .rd_addr      (rd_ptr_q),
            .rd_data      (bank_rd_data[b]),
            .release_bank (bank_release[b]),
            .full         (bank_full[b])
        );
    end

    // Stream outputs come only from registered state, never from out_ready.
    always_comb begin
        out_valid = bank_full[rd_bank_q];
        out_data  = out_valid ? bank_rd_data[rd_bank_q] : '0;
        out_index = rd_ptr_q;
        out_last  = out_valid && at_last;
        overflow  = overflow_q;
        addr_err  = addr_err_q;
    end

endmodule

// File: tb/tb_cell_in_pingpong_buffer.sv
// Bench for the cell input ping-pong buffer: a frame-level model predicts the
// stream every cycle, and directed tests pin exact drained sequences.
module tb_cell_in_pingpong_buffer;
    import lstm_acc_pkg::*;

    logic         sys_clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         we_load_cell;
    feature_idx_t address_write_load_cell;
    element_t     cell_in_buffer_data_in;
    logic         out_valid;
    logic         out_ready;
    element_t     out_data;
    feature_idx_t out_index;
    logic         out_last;
    logic         overflow;
    logic         addr_err;

    int checkCount = 0;
    int passCount  = 0;

    // Model state: the frame being filled, plus completed frames awaiting drain.
    element_t                  fillData  [M];
    bit                        fillValid [M];
    int                        fillCount;
    logic [M*ELEMENT_BITS-1:0] doneQ [$];
    int                        drainPtr;
    bit                        mOverflow;
    bit                        mAddrErr;

    // Elements actually handed to the cell.
    int obsData  [$];
    int obsIndex [$];
    int obsLast  [$];
    int expQ     [$];

    always #5 sys_clk = ~sys_clk;

    cell_in_pingpong_buffer dut (
        .sys_clk                 (sys_clk),
        .reset_n                 (reset_n),
        .clear                   (clear),
        .we_load_cell            (we_load_cell),
        .address_write_load_cell (address_write_load_cell),
        .cell_in_buffer_data_in  (cell_in_buffer_data_in),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .out_index               (out_index),
        .out_last                (out_last),
        .overflow                (overflow),
        .addr_err                (addr_err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic modelReset();
        for (int i = 0; i < M; i++) begin
            fillData[i]  = '0;
            fillValid[i] = 1'b0;
        end
        fillCount = 0;
        doneQ.delete();
        drainPtr  = 0;
        mOverflow = 1'b0;
        mAddrErr  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic modelStep();
        int pend;
        int a;
        logic [M*ELEMENT_BITS-1:0] frame;
        pend = doneQ.size();
        a    = int'(address_write_load_cell);
        if (clear) begin
            modelReset();
            return;
        end
        if (we_load_cell) begin
            if (a >= M) mAddrErr = 1'b1;
            else if (pend >= 2) mOverflow = 1'b1;
            else begin
                fillData[a] = cell_in_buffer_data_in;
                if (!fillValid[a]) begin
                    fillValid[a] = 1'b1;
                    fillCount++;
                end
                if (fillCount == M) begin
                    for (int i = 0; i < M; i++) begin
                        frame[i*ELEMENT_BITS +: ELEMENT_BITS] = fillData[i];
                        fillValid[i] = 1'b0;
                    end
                    doneQ.push_back(frame);
                    fillCount = 0;
                end
            end
        end
        if (pend > 0 && out_ready) begin
            drainPtr++;
            if (drainPtr == M) begin
                void'(doneQ.pop_front());
                drainPtr = 0;
            end
        end
    endtask

    // Per-cycle compare, handshake capture and model advance, midway before the rising edge.
    initial begin
        modelReset();
        forever begin
            logic [M*ELEMENT_BITS-1:0] head;
            bit expValid;
            @(negedge sys_clk);
            #4;
            expValid = (doneQ.size() > 0);
            checkOutput("cyc_valid", int'(out_valid), int'(expValid));
            checkOutput("cyc_index", int'(out_index), drainPtr);
            checkOutput("cyc_last", int'(out_last), int'(expValid && drainPtr == M - 1));
            checkOutput("cyc_overflow", int'(overflow), int'(mOverflow));
            checkOutput("cyc_addr_err", int'(addr_err), int'(mAddrErr));
            if (expValid) begin
                head = doneQ[0];
                checkOutput("cyc_data", int'(out_data), int'(head[drainPtr*ELEMENT_BITS +: ELEMENT_BITS]));
            end else if (!reset_n) begin
                checkOutput("cyc_data_reset", int'(out_data), 0);
            end
            if (reset_n && !clear && out_valid && out_ready) begin
                obsData.push_back(int'(out_data));
                obsIndex.push_back(int'(out_index));
                obsLast.push_back(int'(out_last));
            end
            if (!reset_n) modelReset();
            else modelStep();
        end
    end

    // Drive one cycle of inputs, then return the write and clear strobes to idle.
    task automatic applyStimulus(input logic we, input int addr, input int data, input logic clr);
        we_load_cell            = we;
        address_write_load_cell = FEATURE_BITS'(addr);
        cell_in_buffer_data_in  = ELEMENT_BITS'(data);
        clear                   = clr;
        @(negedge sys_clk);
        #2;
        we_load_cell = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #2;
        end
    endtask

    task automatic writeFrame(input int base);
        for (int i = 0; i < M; i++) applyStimulus(1'b1, i, base + i, 1'b0);
    endtask

    // Compare the captured handshakes against the hand-listed expected stream.
    task automatic expectDrain(input string name);
        checkOutput($sformatf("%s_count", name), obsData.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsData.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", name, i), obsData[i], expQ[i]);
            checkOutput($sformatf("%s_index%0d", name, i), obsIndex[i], i % M);
            checkOutput($sformatf("%s_last%0d", name, i), obsLast[i], int'((i % M) == M - 1));
        end
        obsData.delete();
        obsIndex.delete();
        obsLast.delete();
        expQ.delete();
    endtask

    initial begin
        reset_n                 = 1'b0;
        clear                   = 1'b0;
        we_load_cell            = 1'b0;
        address_write_load_cell = '0;
        cell_in_buffer_data_in  = '0;
        out_ready               = 1'b0;
        idle(2);
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_addr_err", int'(addr_err), 0);
        reset_n = 1'b1;
        idle(1);

        $display("[TB] frame fill and drain");
        out_ready = 1'b1;
        writeFrame(1);
        checkOutput("t1_valid_rise", int'(out_valid), 1);
        checkOutput("t1_first_data", int'(out_data), 1);
        idle(12);
        for (int v = 1; v <= 9; v++) expQ.push_back(v);
        expectDrain("t1");
        checkOutput("t1_valid_after", int'(out_valid), 0);

        $display("[TB] out-of-order and duplicate writes");
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8 - i, 10 + i, 1'b0);
        applyStimulus(1'b1, 3, 99, 1'b0);
        checkOutput("t2_not_full_after_dup", int'(out_valid), 0);
        applyStimulus(1'b1, 0, 18, 1'b0);
        checkOutput("t2_full", int'(out_valid), 1);
        out_ready = 1'b1;
        idle(12);
        expQ = '{18, 17, 16, 99, 14, 13, 12, 11, 10};
        expectDrain("t2");

        $display("[TB] backpressure and ping-pong");
        out_ready = 1'b0;
        writeFrame(1);
        writeFrame(11);
        checkOutput("t3_no_overflow", int'(overflow), 0);
        checkOutput("t3_valid", int'(out_valid), 1);
        checkOutput("t3_head_data", int'(out_data), 1);
        out_ready = 1'b1;
        idle(22);
        for (int v = 1; v <= 9; v++) expQ.push_back(v);
        for (int v = 11; v <= 19; v++) expQ.push_back(v);
        expectDrain("t3");

        $display("[TB] overflow");
        out_ready = 1'b0;
        writeFrame(31);
        writeFrame(41);
        checkOutput("t4_pre_overflow", int'(overflow), 0);
        applyStimulus(1'b1, 0, 55, 1'b0);
        checkOutput("t4_overflow_set", int'(overflow), 1);
        idle(3);
        checkOutput("t4_overflow_sticky", int'(overflow), 1);
        out_ready = 1'b1;
        idle(22);
        for (int v = 31; v <= 39; v++) expQ.push_back(v);
        for (int v = 41; v <= 49; v++) expQ.push_back(v);
        expectDrain("t4");
        checkOutput("t4_overflow_end", int'(overflow), 1);

        $display("[TB] address error");
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("t5_clear_overflow", int'(overflow), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, i + 1, 1'b0);
        applyStimulus(1'b1, 12, 7, 1'b0);
        checkOutput("t5_addr_err", int'(addr_err), 1);
        for (int i = 4; i < 8; i++) applyStimulus(1'b1, i, i + 1, 1'b0);
        checkOutput("t5_no_early_frame", int'(out_valid), 0);
        applyStimulus(1'b1, 8, 9, 1'b0);
        checkOutput("t5_frame_done", int'(out_valid), 1);
        idle(12);
        for (int v = 1; v <= 9; v++) expQ.push_back(v);
        expectDrain("t5");
        checkOutput("t5_addr_err_sticky", int'(addr_err), 1);

        $display("[TB] clear mid-operation");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 70 + i, 1'b0);
        applyStimulus(1'b1, 4, 119, 1'b1);
        checkOutput("t6_valid", int'(out_valid), 0);
        checkOutput("t6_overflow", int'(overflow), 0);
        checkOutput("t6_addr_err", int'(addr_err), 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i, 21 + i, 1'b0);
        checkOutput("t6_no_stale_frame", int'(out_valid), 0);
        applyStimulus(1'b1, 8, 29, 1'b0);
        checkOutput("t6_frame_done", int'(out_valid), 1);
        out_ready = 1'b1;
        idle(12);
        for (int v = 21; v <= 29; v++) expQ.push_back(v);
        expectDrain("t6");
        checkOutput("t6_valid_end", int'(out_valid), 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
